riscv_fetch_queue: RTL and testbench

//  Decoupled instruction-fetch front end for the next-generation hart. Issues

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/riscv_sync_fifo.sv | 67 ++++++
 rtl/riscv_fetch_queue.sv | 111 +++++++++++
 tb/tb_riscv_fetch_queue.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction-fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package riscv_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RV_NOP       = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // One buffered fetch: the word together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         instr;
  } fetch_entry_t;

  // Width of a counter that must hold every value 0..depth without wrapping.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/riscv_sync_fifo.sv
// Synchronous FIFO with single-cycle flush and an occupancy count output.
// Latency: a pushed word is visible at the head in the next cycle.
// Backpressure: push while full and pop while empty are ignored; flush wins over both.
module riscv_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push && !flush && (count_q != CW'(DEPTH));
  assign do_pop  = pop && !flush && (count_q != '0);
  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointer/occupancy: flush empties, otherwise independent push/pop accounting.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is qualified by occupancy, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/riscv_fetch_queue.sv
// Decoupled fetch front end: sequential req/gnt/rvalid fetch into a DEPTH-entry queue.
// Latency: rvalid in cycle N gives instr_valid in N+1; 1 instr/cycle with 1-cycle memory.
// Backpressure: requests stop once queued + in-flight reaches DEPTH; instr_ready low holds the head.
module riscv_fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned EW = XLEN + 32;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     inflight_total;
  logic [XLEN-1:0] redirect_pc_aligned;
  logic            grant, retire, push, pop;
  logic [EW-1:0]   push_dat, head_dat;

  assign redirect_pc_aligned = redirect_pc & ~XLEN'(3);

  // Issue: the queued-plus-in-flight limit guarantees every response has a free slot.
  always_comb begin
    inflight_total = {1'b0, fifo_count} + {1'b0, outstanding_q};
    imem_req       = rst_n && !redirect && (inflight_total < (CW+1)'(DEPTH));
    imem_addr      = fetch_pc_q;
    grant          = imem_req && imem_gnt;
  end

  // Response/output side: stale words are dropped while discard is non-zero or on redirect.
  always_comb begin
    retire      = imem_rvalid && (outstanding_q != '0);
    push        = imem_rvalid && (discard_q == '0) && !redirect;
    push_dat    = {resp_pc_q, imem_rdata};
    instr_valid = (fifo_count != '0);
    pop         = instr_valid && instr_ready && !redirect;
    instr       = instr_valid ? head_dat[31:0] : RV_NOP;
    instr_pc    = instr_valid ? head_dat[EW-1:32] : '0;
  end

  // Next-state for PCs and counters; redirect overrides everything.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (grant && !retire)      outstanding_d = outstanding_q + CW'(1);
    else if (!grant && retire) outstanding_d = outstanding_q - CW'(1);

    if (redirect) begin
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      // Every request still in flight after this cycle belongs to the old stream.
      discard_d  = outstanding_q - CW'(retire);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push)  resp_pc_d  = resp_pc_q + XLEN'(4);
      if (imem_rvalid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  riscv_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (head_dat),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Randomized scoreboard bench for riscv_fetch_queue with an in-order variable-latency memory.
// Latency: model pushes expected words on accepted rvalid; monitor checks them on each pop.
// Backpressure: grant, rvalid, ready and redirect are randomized per phase.
module tb_riscv_fetch_queue;
  import riscv_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt = 1'b0;
  logic            imem_rvalid = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic            redirect = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            instr_valid;
  logic            instr_ready = 1'b0;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;

  riscv_fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC ('0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned epoch;
    int          cyc;
  } mreq_t;

  mreq_t        mem_q[$];   // requests accepted by memory, oldest first
  fetch_entry_t exp_q[$];   // words the queue should be holding, oldest first

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = -1;
  int          phase = 0;
  int          p_gnt = 100, p_rv = 100, p_rdy = 100, p_redir = 0;
  logic [31:0] next_pc = '0;
  int unsigned epoch = 0;
  logic        hold_q = 1'b0;
  logic        active = 1'b0;
  logic        pend_push, pend_flush;
  fetch_entry_t pend_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: issue rule, address sequence, and which responses survive.
  always begin
    logic  exp_req;
    mreq_t m;
    mreq_t n;
    @(negedge clk);
    #2;
    pend_push  = 1'b0;
    pend_flush = 1'b0;
    if (rst_n && active) begin
      exp_req = !redirect && ((exp_q.size() + mem_q.size()) < DEPTH);
      chk("imem_req", imem_req, exp_req);
      if (hold_q && !redirect) chk("req_hold", imem_req, 1'b1);
      if (imem_req) chk("imem_addr", imem_addr, next_pc);
      if (imem_rvalid && mem_q.size() > 0) begin
        m = mem_q.pop_front();
        if (m.epoch == epoch && !redirect) begin
          pend_push    = 1'b1;
          pend_e.pc    = m.addr;
          pend_e.instr = m.data;
        end
      end
      if (imem_req && imem_gnt) begin
        n.addr  = next_pc;
        n.data  = $urandom;
        n.epoch = epoch;
        n.cyc   = cyc;
        mem_q.push_back(n);
        next_pc = next_pc + 32'd4;
      end
      hold_q = imem_req && !imem_gnt;
      if (redirect) begin
        epoch++;
        next_pc    = redirect_pc & ~32'd3;
        pend_flush = 1'b1;
        hold_q     = 1'b0;
      end
    end
    #2;
    if (rst_n && active) begin
      if (pend_flush) exp_q.delete();
      if (pend_push)  exp_q.push_back(pend_e);
    end
  end

  // Monitor: compare the head against the scoreboard whenever decode takes it.
  always begin
    fetch_entry_t e;
    @(negedge clk);
    #3;
    if (rst_n && active) begin
      chk("instr_valid", instr_valid, exp_q.size() != 0);
      if (!instr_valid) begin
        chk("nop_when_empty", instr, RV_NOP);
      end else if (instr_ready && !redirect && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("instr_pc", instr_pc, e.pc);
        chk("instr", instr, e.instr);
      end
      if (phase == 1 && cyc >= 2) chk("stream_rate", instr_valid, 1'b1);
    end
  end

  task automatic drive_cycle(input logic do_redir, input logic [31:0] rpc);
    @(negedge clk);
    cyc++;
    imem_gnt = ($urandom_range(99) < p_gnt);
    if (mem_q.size() > 0 && mem_q[0].cyc < cyc && $urandom_range(99) < p_rv) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].data;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    instr_ready = ($urandom_range(99) < p_rdy);
    if (do_redir) begin
      redirect    = 1'b1;
      redirect_pc = rpc;
    end else if ($urandom_range(99) < p_redir) begin
      redirect    = 1'b1;
      redirect_pc = $urandom;
    end else begin
      redirect    = 1'b0;
      redirect_pc = $urandom;
    end
  endtask

  task automatic run(input int n);
    repeat (n) drive_cycle(1'b0, 32'h0);
  endtask

  // Asserts reset off the clock edge and checks that outputs clear without a clock.
  task automatic do_reset();
    #1;
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    #1;
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, RV_NOP);
    chk("rst_instr_pc", instr_pc, 32'h0);
    mem_q.delete();
    exp_q.delete();
    next_pc = '0;
    epoch   = 0;
    hold_q  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = -1;
  endtask

  initial begin
    do_reset();
    active = 1'b1;

    // Full-rate streaming from reset.
    phase = 1;
    p_gnt = 100; p_rv = 100; p_rdy = 100; p_redir = 0;
    run(20);
    phase = 0;

    // Decode stalled: issue must stop at DEPTH, then resume without loss.
    p_rdy = 0;
    run(12);
    p_rdy = 100;
    run(12);

    // Grant withheld at 0x10: request and address must hold.
    p_gnt = 0;
    drive_cycle(1'b1, 32'h10);
    run(5);
    p_gnt = 100;
    run(6);

    // Three requests in flight, then redirect to 0x200.
    p_rv = 0;
    drive_cycle(1'b1, 32'h0);
    run(3);
    drive_cycle(1'b1, 32'h200);
    p_rv = 100;
    run(10);

    // Redirect coinciding with rvalid and pop, then again to 0x400.
    run(5);
    drive_cycle(1'b1, 32'h300);
    drive_cycle(1'b1, 32'h400);
    run(10);

    // Address wrap and misaligned redirect target.
    drive_cycle(1'b1, 32'hFFFF_FFF8);
    run(8);
    drive_cycle(1'b1, 32'h103);
    run(8);

    // Randomized traffic mixes.
    for (int ph = 0; ph < 6; ph++) begin
      p_gnt   = $urandom_range(100, 30);
      p_rv    = $urandom_range(100, 20);
      p_rdy   = $urandom_range(100, 20);
      p_redir = $urandom_range(8, 0);
      run(300);
    end

    // Reset while the queue is full and requests are in flight.
    p_gnt = 100; p_rv = 100; p_rdy = 0; p_redir = 0;
    run(10);
    do_reset();
    phase = 1;
    p_rdy = 100;
    run(15);
    phase = 0;

    // Drain.
    p_gnt = 0;
    run(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
